// File: rtl/hbfp_pkg.sv
// -----------------------------------------------------------------------------
// hbfp_pkg
// Shared definitions for the HBFP dot-sum scheduler:
//   - default widths for mantissa, exponent and accumulator
//   - default beats per block
//   - scheduler state encoding (IDLE -> ACCUM -> OUT)
//   - saturation bounds for the default accumulator width
// Optional build macro used by the scheduler: HBFP_ACC_SAT_EN (saturating
// accumulate instead of two's-complement wrap).
// -----------------------------------------------------------------------------
package hbfp_pkg;

   localparam int MAN_W_DEF = 12;
   localparam int EXP_W_DEF = 8;
   localparam int ACC_W_DEF = 16;
   localparam int BEATS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   // Saturation bounds for the default accumulator width. The scheduler
   // derives the same bounds for its own ACC_W parameter.
   localparam logic signed [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic signed [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/add_tree4.sv
// -----------------------------------------------------------------------------
// add_tree4
// Combinational 4-input signed adder tree. Two pairwise sums of MAN_W+1 bits
// feed a final MAN_W+2 bit sum, which cannot overflow for any input.
// Ports:
//   lane_0..lane_3  in   MAN_W    signed lane mantissas
//   sum             out  MAN_W+2  signed sum of the four lanes
// -----------------------------------------------------------------------------
module add_tree4 #(
   parameter int MAN_W = 12
) (
   input  logic signed [MAN_W-1:0] lane_0,
   input  logic signed [MAN_W-1:0] lane_1,
   input  logic signed [MAN_W-1:0] lane_2,
   input  logic signed [MAN_W-1:0] lane_3,
   output logic signed [MAN_W+1:0] sum
);

   logic signed [MAN_W:0] pair_lo;
   logic signed [MAN_W:0] pair_hi;

   assign pair_lo = (MAN_W+1)'(lane_0) + (MAN_W+1)'(lane_1);
   assign pair_hi = (MAN_W+1)'(lane_2) + (MAN_W+1)'(lane_3);
   assign sum     = (MAN_W+2)'(pair_lo) + (MAN_W+2)'(pair_hi);

endmodule

// File: rtl/hbfp_dot_sched.sv
// -----------------------------------------------------------------------------
// hbfp_dot_sched
// Round-robin scheduler sharing one 4-lane signed adder tree between two HBFP
// requesters. The tree is locked to the granted requester for a whole block of
// BEATS beats; per-beat tree sums accumulate into an ACC_W accumulator and the
// block result (sum, exponent, source, overflow) is offered on a valid/ready
// output.
// Build option: HBFP_ACC_SAT_EN -> accumulator saturates on overflow
// (default: two's-complement wrap). Overflow flag is sticky per block either way.
// Ports:
//   clock, reset                     clock (rising edge), async active-low reset
//   io_reqN_valid / io_reqN_ready    requester N beat handshake
//   io_reqN_man_0..3                 requester N signed lane mantissas
//   io_reqN_exp                      requester N block exponent (first beat)
//   io_out_valid / io_out_ready      result handshake
//   io_out_man / exp / src / ovf     block sum, exponent, source, overflow
//   io_busy                          high whenever not IDLE
// -----------------------------------------------------------------------------
module hbfp_dot_sched
   import hbfp_pkg::*;
#(
   parameter int MAN_W = MAN_W_DEF,
   parameter int EXP_W = EXP_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int BEATS = BEATS_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    io_req0_valid,
   output logic                    io_req0_ready,
   input  logic signed [MAN_W-1:0] io_req0_man_0,
   input  logic signed [MAN_W-1:0] io_req0_man_1,
   input  logic signed [MAN_W-1:0] io_req0_man_2,
   input  logic signed [MAN_W-1:0] io_req0_man_3,
   input  logic        [EXP_W-1:0] io_req0_exp,
   input  logic                    io_req1_valid,
   output logic                    io_req1_ready,
   input  logic signed [MAN_W-1:0] io_req1_man_0,
   input  logic signed [MAN_W-1:0] io_req1_man_1,
   input  logic signed [MAN_W-1:0] io_req1_man_2,
   input  logic signed [MAN_W-1:0] io_req1_man_3,
   input  logic        [EXP_W-1:0] io_req1_exp,
   output logic                    io_out_valid,
   input  logic                    io_out_ready,
   output logic signed [ACC_W-1:0] io_out_man,
   output logic        [EXP_W-1:0] io_out_exp,
   output logic                    io_out_src,
   output logic                    io_out_ovf,
   output logic                    io_busy
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_t                  state_reg, state_next;
   logic signed [ACC_W-1:0] acc_reg,   acc_next;
   logic [BEAT_W-1:0]       beat_reg,  beat_next;
   logic                    prio_reg,  prio_next;
   logic                    grant_reg, grant_next;
   logic [EXP_W-1:0]        exp_reg,   exp_next;
   logic                    ovf_reg,   ovf_next;

   // Lane selection: the granted requester drives the shared tree.
   logic signed [MAN_W-1:0] req0_man [4];
   logic signed [MAN_W-1:0] req1_man [4];
   logic signed [MAN_W-1:0] sel_man  [4];

   assign req0_man[0] = io_req0_man_0;
   assign req0_man[1] = io_req0_man_1;
   assign req0_man[2] = io_req0_man_2;
   assign req0_man[3] = io_req0_man_3;
   assign req1_man[0] = io_req1_man_0;
   assign req1_man[1] = io_req1_man_1;
   assign req1_man[2] = io_req1_man_2;
   assign req1_man[3] = io_req1_man_3;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mux
      assign sel_man[gi] = grant_reg ? req1_man[gi] : req0_man[gi];
   end

   logic                    sel_valid;
   logic [EXP_W-1:0]        sel_exp;
   logic signed [MAN_W+1:0] tree_sum;

   assign sel_valid = grant_reg ? io_req1_valid : io_req0_valid;
   assign sel_exp   = grant_reg ? io_req1_exp   : io_req0_exp;

   add_tree4 #(.MAN_W(MAN_W)) u_tree (
      .lane_0 (sel_man[0]),
      .lane_1 (sel_man[1]),
      .lane_2 (sel_man[2]),
      .lane_3 (sel_man[3]),
      .sum    (tree_sum)
   );

   // One extra bit exposes signed overflow: the top two bits disagree.
   logic signed [ACC_W:0]   sum_wide;
   logic                    add_ovf;
   logic signed [ACC_W-1:0] acc_sum;

   assign sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(tree_sum);
   assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

`ifdef HBFP_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   // The true sign of an overflowed sum is the extra top bit.
   assign acc_sum = add_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
`else
   assign acc_sum = sum_wide[ACC_W-1:0];
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         beat_reg  <= '0;
         prio_reg  <= 1'b0;
         grant_reg <= 1'b0;
         exp_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         beat_reg  <= beat_next;
         prio_reg  <= prio_next;
         grant_reg <= grant_next;
         exp_reg   <= exp_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      beat_next     = beat_reg;
      prio_next     = prio_reg;
      grant_next    = grant_reg;
      exp_next      = exp_reg;
      ovf_next      = ovf_reg;
      io_req0_ready = 1'b0;
      io_req1_ready = 1'b0;

      case (state_reg)
         IDLE: begin
            if (io_req0_valid || io_req1_valid) begin
               // Priority requester wins if valid, otherwise the other one.
               grant_next = prio_reg ? io_req1_valid : ~io_req0_valid;
               state_next = ACCUM;
               acc_next   = '0;
               beat_next  = '0;
               ovf_next   = 1'b0;
            end
         end
         ACCUM: begin
            io_req0_ready = ~grant_reg;
            io_req1_ready = grant_reg;
            if (sel_valid) begin
               acc_next = acc_sum;
               ovf_next = ovf_reg | add_ovf;
               if (beat_reg == '0)
                  exp_next = sel_exp;
               if (beat_reg == BEAT_W'(BEATS-1)) begin
                  beat_next  = '0;
                  state_next = OUT;
               end else begin
                  beat_next = beat_reg + BEAT_W'(1);
               end
            end
         end
         OUT: begin
            if (io_out_ready) begin
               state_next = IDLE;
               prio_next  = ~grant_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign io_out_valid = (state_reg == OUT);
   assign io_busy      = (state_reg != IDLE);
   assign io_out_man   = acc_reg;
   assign io_out_exp   = exp_reg;
   assign io_out_src   = grant_reg;
   assign io_out_ovf   = ovf_reg;

endmodule
